mole_field_controller: RTL and testbench



---
 rtl/mole_field_controller.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_mole_field_controller.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_field_controller.sv
// mole_field_controller: whack-a-mole game core.
// Tracks up to MAX_MOLES moles on a ROWS x COLS field. Each mole has a finite lifetime.
// Also runs the IDLE/RUN/DONE game FSM, the seconds countdown and a saturating BCD score.
module mole_field_controller #(
    parameter int         ROWS         = 4,
    parameter int         COLS         = 4,
    parameter int         MAX_MOLES    = 2,
    parameter int         LIFE_TICKS   = 8,
    parameter int         SPAWN_TICKS  = 3,
    parameter int         GAME_SECS    = 60,
    parameter int         MISS_PENALTY = 0,
    parameter logic [7:0] LFSR_SEED    = 8'hA5,
    localparam int        N            = ROWS * COLS,
    localparam int        CW           = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          tick,
    input  logic          sec_tick,
    input  logic          hit_valid,
    input  logic [CW-1:0] hit_cell,
    output logic [N-1:0]  mole_map,
    output logic          running,
    output logic          done,
    output logic          hit_ok,
    output logic          miss,
    output logic          expire,
    output logic [11:0]   score_bcd,
    output logic [6:0]    time_left
);

    localparam int         IW           = (MAX_MOLES > 1) ? $clog2(MAX_MOLES) : 1;
    localparam int         LW           = $clog2(LIFE_TICKS + 1);
    localparam int         SW           = $clog2(SPAWN_TICKS + 1);
    localparam logic [7:0] N8           = 8'(N);
    localparam logic [7:0] SEED_EFF     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [LW-1:0] LIFE_LOAD = LW'(LIFE_TICKS);
    localparam logic [SW-1:0] SPAWN_LOAD = SW'(SPAWN_TICKS);
    localparam logic [6:0] GAME_LOAD    = 7'(GAME_SECS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Saturating BCD increment; 999 stays 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] d0, d1, d2;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        if (v == 12'h999) begin
            d0 = v[3:0];
        end else if (d0 != 4'd9) begin
            d0 = d0 + 4'd1;
        end else begin
            d0 = 4'd0;
            if (d1 != 4'd9) begin
                d1 = d1 + 4'd1;
            end else begin
                d1 = 4'd0;
                d2 = d2 + 4'd1;
            end
        end
        return {d2, d1, d0};
    endfunction

    // Saturating BCD decrement; 000 stays 000.
    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] d0, d1, d2;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        if (v == 12'h000) begin
            d0 = 4'd0;
        end else if (d0 != 4'd0) begin
            d0 = d0 - 4'd1;
        end else begin
            d0 = 4'd9;
            if (d1 != 4'd0) begin
                d1 = d1 - 4'd1;
            end else begin
                d1 = 4'd9;
                d2 = d2 - 4'd1;
            end
        end
        return {d2, d1, d0};
    endfunction

    state_t                 state_r, state_n;
    logic [7:0]             lfsr_r, lfsr_n;
    logic [MAX_MOLES-1:0]   slot_valid_r, valid_n;
    logic [7:0]             slot_cell_r [MAX_MOLES];
    logic [7:0]             cell_n      [MAX_MOLES];
    logic [LW-1:0]          slot_life_r [MAX_MOLES];
    logic [LW-1:0]          life_n      [MAX_MOLES];
    logic [SW-1:0]          spawn_cnt_r, cnt_n, cnt_dec_s;
    logic [11:0]            score_r, score_n;
    logic [6:0]             time_r, time_n;
    logic [N-1:0]           map_r, map_n;
    logic                   running_r, running_n, done_r, done_n;
    logic                   hit_ok_r, hit_ok_n, miss_r, miss_n, expire_r, expire_n;
    logic [7:0]             cand_s, hit_cell8_s;
    logic                   cand_occ_s, hit_match_s, free_found_s;
    logic [IW-1:0]          hit_idx_s, free_idx_s;

    // Next-state logic: FSM, slot spawn/expiry/hit, score, countdown and LFSR.
    always_comb begin
        state_n      = state_r;
        lfsr_n       = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        valid_n      = slot_valid_r;
        cell_n       = slot_cell_r;
        life_n       = slot_life_r;
        cnt_n        = spawn_cnt_r;
        score_n      = score_r;
        time_n       = time_r;
        hit_ok_n     = 1'b0;
        miss_n       = 1'b0;
        expire_n     = 1'b0;
        cand_s       = lfsr_r % N8;
        hit_cell8_s  = 8'(hit_cell);
        cand_occ_s   = 1'b0;
        hit_match_s  = 1'b0;
        hit_idx_s    = '0;
        free_found_s = 1'b0;
        free_idx_s   = '0;
        cnt_dec_s    = (spawn_cnt_r == '0) ? '0 : spawn_cnt_r - SW'(1);

        // All lookups use only registered slot state, so a slot freed this cycle is not yet free.
        for (int i = 0; i < MAX_MOLES; i++) begin
            if (slot_valid_r[i] && (slot_cell_r[i] == cand_s)) begin
                cand_occ_s = 1'b1;
            end else begin
                cand_occ_s = cand_occ_s;
            end
            if (slot_valid_r[i] && (slot_cell_r[i] == hit_cell8_s)) begin
                hit_match_s = 1'b1;
                hit_idx_s   = IW'(i);
            end else begin
                hit_match_s = hit_match_s;
            end
            if (!slot_valid_r[i] && !free_found_s) begin
                free_found_s = 1'b1;
                free_idx_s   = IW'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n = ST_RUN;
                    valid_n = '0;
                    score_n = 12'h000;
                    time_n  = GAME_LOAD;
                    cnt_n   = SPAWN_LOAD;
                end else begin
                    state_n = state_r;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    for (int i = 0; i < MAX_MOLES; i++) begin
                        if (slot_valid_r[i]) begin
                            life_n[i] = slot_life_r[i] - LW'(1);
                            if (slot_life_r[i] == LW'(1)) begin
                                valid_n[i] = 1'b0;
                                // A press on the same mole this cycle takes precedence over expiry.
                                if (!(hit_valid && hit_match_s && (hit_idx_s == IW'(i)))) begin
                                    expire_n = 1'b1;
                                end else begin
                                    expire_n = expire_n;
                                end
                            end else begin
                                valid_n[i] = slot_valid_r[i];
                            end
                        end else begin
                            life_n[i] = slot_life_r[i];
                        end
                    end
                    if (cnt_dec_s == '0) begin
                        if (free_found_s && !cand_occ_s) begin
                            valid_n[free_idx_s] = 1'b1;
                            cell_n[free_idx_s]  = cand_s;
                            life_n[free_idx_s]  = LIFE_LOAD;
                            cnt_n               = SPAWN_LOAD;
                        end else begin
                            cnt_n = '0;
                        end
                    end else begin
                        cnt_n = cnt_dec_s;
                    end
                end else begin
                    cnt_n = spawn_cnt_r;
                end

                if (hit_valid) begin
                    if (hit_match_s) begin
                        valid_n[hit_idx_s] = 1'b0;
                        hit_ok_n           = 1'b1;
                        score_n            = bcd_inc(score_r);
                    end else begin
                        miss_n = 1'b1;
                        if (MISS_PENALTY != 0) begin
                            score_n = bcd_dec(score_r);
                        end else begin
                            score_n = score_r;
                        end
                    end
                end else begin
                    score_n = score_r;
                end

                if (sec_tick) begin
                    if (time_r == 7'd1) begin
                        state_n = ST_DONE;
                        time_n  = 7'd0;
                        valid_n = '0;
                    end else begin
                        time_n = time_r - 7'd1;
                    end
                end else begin
                    time_n = time_r;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        map_n = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < MAX_MOLES; i++) begin
                if (valid_n[i] && (cell_n[i] == 8'(j))) begin
                    map_n[j] = 1'b1;
                end else begin
                    map_n[j] = map_n[j];
                end
            end
        end

        running_n = (state_n == ST_RUN);
        done_n    = (state_n == ST_DONE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            lfsr_r       <= SEED_EFF;
            slot_valid_r <= '0;
            for (int i = 0; i < MAX_MOLES; i++) begin
                slot_cell_r[i] <= 8'h00;
                slot_life_r[i] <= '0;
            end
            spawn_cnt_r  <= '0;
            score_r      <= 12'h000;
            time_r       <= 7'd0;
            map_r        <= '0;
            running_r    <= 1'b0;
            done_r       <= 1'b0;
            hit_ok_r     <= 1'b0;
            miss_r       <= 1'b0;
            expire_r     <= 1'b0;
        end else begin
            state_r      <= state_n;
            lfsr_r       <= lfsr_n;
            slot_valid_r <= valid_n;
            slot_cell_r  <= cell_n;
            slot_life_r  <= life_n;
            spawn_cnt_r  <= cnt_n;
            score_r      <= score_n;
            time_r       <= time_n;
            map_r        <= map_n;
            running_r    <= running_n;
            done_r       <= done_n;
            hit_ok_r     <= hit_ok_n;
            miss_r       <= miss_n;
            expire_r     <= expire_n;
        end
    end

    assign mole_map  = map_r;
    assign running   = running_r;
    assign done      = done_r;
    assign hit_ok    = hit_ok_r;
    assign miss      = miss_r;
    assign expire    = expire_r;
    assign score_bcd = score_r;
    assign time_left = time_r;

endmodule

// File: tb/tb_mole_field_controller.sv
// Self-checking bench for mole_field_controller: randomized and directed play
// checked every cycle against an integer-level game model.
module tb_mole_field_controller;

    localparam int         ROWS  = 3;
    localparam int         COLS  = 4;
    localparam int         NC    = ROWS * COLS;
    localparam int         MAXM  = 2;
    localparam int         LIFE  = 8;
    localparam int         SPAWN = 3;
    localparam int         GAME  = 60;
    localparam int         PEN   = 1;
    localparam logic [7:0] SEED  = 8'hA5;

    logic        clk = 1'b0;
    logic        rst, start, tick, sec_tick, hit_valid;
    logic [3:0]  hit_cell;
    logic [11:0] mole_map;
    logic        running, done, hit_ok, miss, expire;
    logic [11:0] score_bcd;
    logic [6:0]  time_left;

    mole_field_controller #(
        .ROWS(ROWS), .COLS(COLS), .MAX_MOLES(MAXM), .LIFE_TICKS(LIFE),
        .SPAWN_TICKS(SPAWN), .GAME_SECS(GAME), .MISS_PENALTY(PEN), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .tick(tick), .sec_tick(sec_tick),
        .hit_valid(hit_valid), .hit_cell(hit_cell), .mole_map(mole_map),
        .running(running), .done(done), .hit_ok(hit_ok), .miss(miss),
        .expire(expire), .score_bcd(score_bcd), .time_left(time_left)
    );

    always #5 clk = ~clk;

    // Game model: 0 = idle, 1 = playing, 2 = finished
    int         m_state;
    bit         m_valid [MAXM];
    int         m_cell  [MAXM];
    int         m_life  [MAXM];
    int         m_cnt, m_score, m_time;
    logic [7:0] m_lfsr;
    bit         e_hit, e_miss, e_exp;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_map();
        logic [31:0] m = 32'd0;
        for (int i = 0; i < MAXM; i++) if (m_valid[i]) m[m_cell[i]] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] to_bcd(input int v);
        return {20'd0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_score = 0; m_time = 0; m_lfsr = SEED;
        e_hit = 0; e_miss = 0; e_exp = 0;
        for (int i = 0; i < MAXM; i++) begin m_valid[i] = 0; m_cell[i] = 0; m_life[i] = 0; end
    endtask

    task automatic model_update(input bit st, input bit tk, input bit sc, input bit hv, input int hc);
        bit pv [MAXM];
        int cand, h, f;
        bit occ;
        cand = int'(m_lfsr) % NC;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        e_hit = 0; e_miss = 0; e_exp = 0;
        if (m_state != 1) begin
            if (st) begin
                m_state = 1; m_score = 0; m_time = GAME; m_cnt = SPAWN;
                for (int i = 0; i < MAXM; i++) m_valid[i] = 0;
            end
        end else begin
            h = -1; f = -1; occ = 0;
            for (int i = 0; i < MAXM; i++) begin
                pv[i] = m_valid[i];
                if (pv[i] && m_cell[i] == hc) h = i;
                if (pv[i] && m_cell[i] == cand) occ = 1;
                if (!pv[i] && f < 0) f = i;
            end
            if (tk) begin
                for (int i = 0; i < MAXM; i++) if (pv[i]) begin
                    m_life[i]--;
                    if (m_life[i] == 0) begin
                        m_valid[i] = 0;
                        if (!(hv && h == i)) e_exp = 1;
                    end
                end
                m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
                if (m_cnt == 0) begin
                    if (f >= 0 && !occ) begin
                        m_valid[f] = 1; m_cell[f] = cand; m_life[f] = LIFE; m_cnt = SPAWN;
                    end
                end
            end
            if (hv) begin
                if (h >= 0) begin
                    m_valid[h] = 0; e_hit = 1;
                    m_score = (m_score < 999) ? m_score + 1 : 999;
                end else begin
                    e_miss = 1;
                    m_score = (m_score - PEN < 0) ? 0 : m_score - PEN;
                end
            end
            if (sc) begin
                if (m_time == 1) begin
                    m_state = 2; m_time = 0;
                    for (int i = 0; i < MAXM; i++) m_valid[i] = 0;
                end else begin
                    m_time--;
                end
            end
        end
    endtask

    task automatic check_all();
        check("mole_map", 32'(mole_map), model_map());
        check("running", 32'(running), 32'(m_state == 1));
        check("done", 32'(done), 32'(m_state == 2));
        check("hit_ok", 32'(hit_ok), 32'(e_hit));
        check("miss", 32'(miss), 32'(e_miss));
        check("expire", 32'(expire), 32'(e_exp));
        check("score_bcd", 32'(score_bcd), to_bcd(m_score));
        check("time_left", 32'(time_left), 32'(m_time));
    endtask

    task automatic step(input bit st, input bit tk, input bit sc, input bit hv, input int hc);
        start = st; tick = tk; sec_tick = sc; hit_valid = hv; hit_cell = 4'(hc);
        @(posedge clk);
        model_update(st, tk, sc, hv, hc);
        #1;
        start = 1'b0; tick = 1'b0; sec_tick = 1'b0; hit_valid = 1'b0;
        check_all();
    endtask

    function automatic int any_mole();
        int c = -1;
        int r = int'($urandom_range(0, MAXM - 1));
        for (int i = 0; i < MAXM; i++) if (m_valid[i] && (c < 0 || i == r)) c = m_cell[i];
        return c;
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; tick = 1'b0; sec_tick = 1'b0; hit_valid = 1'b0; hit_cell = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst = 1'b0;
    endtask

    // Hard stop in case the run ever stalls.
    initial begin
        #5000000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Directed and randomized stimulus sequence.
    initial begin
        int c, extra, empty_cell;
        bit found;
        do_reset();

        // Start and first spawn after SPAWN ticks
        step(1, 0, 0, 0, 0);
        check("start_running", 32'(running), 32'd1);
        check("start_time", 32'(time_left), 32'd60);
        repeat (SPAWN) step(0, 1, 0, 0, 0);
        check("first_spawn_bits", $countones(mole_map), 32'd1);

        // Hit the active mole
        c = any_mole();
        step(0, 0, 0, 1, c);
        check("first_hit_ok", 32'(hit_ok), 32'd1);
        check("first_hit_score", 32'(score_bcd), 32'h001);

        // Random play, including presses on invalid cells 12..15
        for (int k = 0; k < 400; k++) begin
            bit tk = ($urandom_range(0, 1) == 0);
            bit hv = ($urandom_range(0, 2) == 0);
            c = any_mole();
            if (c < 0 || $urandom_range(0, 2) == 0) c = int'($urandom_range(0, 15));
            step(0, tk, 0, hv, c);
            check("max_moles", 32'($countones(mole_map) <= MAXM), 32'd1);
        end

        // Hit and expiry of the same mole in one cycle
        found = 0; c = -1;
        for (int k = 0; k < 200 && !found; k++) begin
            for (int i = 0; i < MAXM; i++) if (m_valid[i] && m_life[i] == 1) begin found = 1; c = m_cell[i]; end
            if (!found) step(0, 1, 0, 0, 0);
        end
        check("expire_wait_bound", 32'(found), 32'd1);
        if (found) begin
            step(0, 1, 0, 1, c);
            check("hit_beats_expire", 32'(hit_ok), 32'd1);
        end

        // Plain expiry: no presses for a full lifetime
        repeat (LIFE + SPAWN + 2) step(0, 1, 0, 0, 0);

        // Miss penalty: bring score to 2 then miss down to 0
        for (int k = 0; k < 2000 && m_score > 2; k++) step(0, 0, 0, 1, 12);
        for (int k = 0; k < 2000 && m_score < 2; k++) begin
            c = any_mole();
            if (c >= 0) step(0, 1, 0, 1, c); else step(0, 1, 0, 0, 0);
        end
        check("score_at_two", 32'(score_bcd), 32'h002);
        empty_cell = 0;
        for (int j = NC - 1; j >= 0; j--) if (!model_map()[j]) empty_cell = j;
        step(0, 0, 0, 1, empty_cell);
        check("miss_empty_pulse", 32'(miss), 32'd1);
        check("miss_empty_score", 32'(score_bcd), 32'h001);
        step(0, 0, 0, 1, NC);
        check("miss_invalid_score", 32'(score_bcd), 32'h000);
        step(0, 0, 0, 1, NC);
        check("miss_floor_score", 32'(score_bcd), 32'h000);

        // Score saturation at 999
        extra = 0;
        for (int k = 0; k < 9000 && extra < 5; k++) begin
            c = any_mole();
            if (c >= 0) begin
                if (m_score == 999) extra++;
                step(0, 1, 0, 1, c);
            end else begin
                step(0, 1, 0, 0, 0);
            end
        end
        check("score_saturated", 32'(score_bcd), 32'h999);

        // Countdown to DONE with play going on
        for (int k = 0; k < GAME; k++) begin
            c = any_mole();
            if (c < 0) c = int'($urandom_range(0, 15));
            step(0, $urandom_range(0, 1) == 0, 1, $urandom_range(0, 1) == 0, c);
        end
        check("done_flag", 32'(done), 32'd1);
        check("done_map_clear", 32'(mole_map), 32'd0);
        check("done_time", 32'(time_left), 32'd0);
        repeat (5) step(0, 1, 1, 1, int'($urandom_range(0, 15)));

        // Restart from DONE
        step(1, 0, 0, 0, 0);
        check("restart_score", 32'(score_bcd), 32'h000);
        check("restart_time", 32'(time_left), 32'd60);
        for (int k = 0; k < 30; k++) begin
            c = any_mole();
            step(1, 1, $urandom_range(0, 3) == 0, c >= 0, (c >= 0) ? c : 0);
        end

        // Asynchronous reset mid-game
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        step(1, 0, 0, 0, 0);
        repeat (SPAWN) step(0, 1, 0, 0, 0);
        check("post_reset_spawn_bits", $countones(mole_map), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
